// File: rtl/reg_8bit_rd_ser.sv
// Read-side serializer for the 8-bit register: on an active-low read enable it
// captures the parallel word and shifts it out one bit per clock.
module reg_8bit_rd_ser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             re_n,
    input  logic [WIDTH-1:0] data_in,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // The shift register always presents the bit currently on ser_out at its
    // outgoing end; advancing it exposes the next bit in the selected order.
    logic [WIDTH-1:0] shreg_adv;
    logic             first_bit;
    logic             next_bit;

    always_comb begin
        if (MSB_FIRST) begin
            shreg_adv = {shreg_q[WIDTH-2:0], 1'b0};
            first_bit = data_in[WIDTH-1];
            next_bit  = shreg_adv[WIDTH-1];
        end else begin
            shreg_adv = {1'b0, shreg_q[WIDTH-1:1]};
            first_bit = data_in[0];
            next_bit  = shreg_adv[0];
        end
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        ser_out_d   = ser_out_q;
        ser_valid_d = ser_valid_q;
        busy_d      = busy_q;
        done_d      = done_q;

        case (state_q)
            IDLE: begin
                if (!re_n) begin
                    shreg_d     = data_in;
                    ser_out_d   = first_bit;
                    ser_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    cnt_d       = '0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_CNT) begin
                    ser_valid_d = 1'b0;
                    ser_out_d   = 1'b0;
                    done_d      = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    shreg_d   = shreg_adv;
                    ser_out_d = next_bit;
                end
            end
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                // Unreachable encoding: fall back to a clean idle.
                state_d     = IDLE;
                ser_out_d   = 1'b0;
                ser_valid_d = 1'b0;
                busy_d      = 1'b0;
                done_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_reg_8bit_rd_ser.sv
// Bench for reg_8bit_rd_ser: MSB-first and LSB-first instances share stimulus
// and are compared every cycle against a transaction-level reference model.
module tb_reg_8bit_rd_ser;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         re_n;
    logic [W-1:0] data_in;

    logic so_m, sv_m, bz_m, dn_m;
    logic so_l, sv_l, bz_l, dn_l;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: pos = -1 when idle, otherwise cycles since capture.
    int           pos = -1;
    logic [W-1:0] word = '0;

    always #5 clk = ~clk;

    reg_8bit_rd_ser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .re_n(re_n), .data_in(data_in),
        .ser_out(so_m), .ser_valid(sv_m), .busy(bz_m), .done(dn_m)
    );

    reg_8bit_rd_ser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .re_n(re_n), .data_in(data_in),
        .ser_out(so_l), .ser_valid(sv_l), .busy(bz_l), .done(dn_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic check_all(input string tag);
        logic v, b, d, bm, bl;
        v  = (pos >= 0) && (pos < W);
        b  = (pos >= 0) && (pos <= W);
        d  = (pos == W);
        bm = v ? word[W-1-pos] : 1'b0;
        bl = v ? word[pos]     : 1'b0;
        chk({tag, ".msb.ser_out"},   32'(so_m), 32'(bm));
        chk({tag, ".msb.ser_valid"}, 32'(sv_m), 32'(v));
        chk({tag, ".msb.busy"},      32'(bz_m), 32'(b));
        chk({tag, ".msb.done"},      32'(dn_m), 32'(d));
        chk({tag, ".lsb.ser_out"},   32'(so_l), 32'(bl));
        chk({tag, ".lsb.ser_valid"}, 32'(sv_l), 32'(v));
        chk({tag, ".lsb.busy"},      32'(bz_l), 32'(b));
        chk({tag, ".lsb.done"},      32'(dn_l), 32'(d));
    endtask

    // Drive inputs (at the falling edge), advance one rising edge, check.
    task automatic cycle(input string tag, input logic r, input logic rn, input logic [W-1:0] d);
        logic was_rst;
        was_rst = rst;
        rst     = r;
        re_n    = rn;
        data_in = d;
        if (r) begin
            pos = -1;
            if (!was_rst) begin
                #1;
                check_all({tag, ".async_rst"});
            end
        end
        @(posedge clk);
        if (rst) pos = -1;
        else if (pos < 0) begin
            if (!re_n) begin
                pos  = 0;
                word = data_in;
            end
        end else begin
            pos++;
            if (pos == W + 1) pos = -1;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; re_n = 1'b0; data_in = 8'hFF;
        #1;
        check_all("reset0");
        @(negedge clk);

        // Reset held with a pending read: nothing moves.
        for (int i = 0; i < 3; i++) cycle("reset_hold", 1'b1, 1'b0, 8'hFF);
        // First edge after release captures.
        cycle("reset_rel", 1'b0, 1'b0, 8'hFF);
        for (int i = 0; i < 10; i++) cycle("ff_word", 1'b0, 1'b1, 8'h00);

        cycle("a5_cap", 1'b0, 1'b0, 8'hA5);
        for (int i = 0; i < 11; i++) cycle("a5_word", 1'b0, 1'b1, 8'h00);

        cycle("01_cap", 1'b0, 1'b0, 8'h01);
        for (int i = 0; i < 11; i++) cycle("01_word", 1'b0, 1'b1, 8'hFF);

        // Back-to-back with re_n held low and data changing mid-word.
        for (int i = 0; i < 3; i++)  cycle("b2b", 1'b0, 1'b0, 8'h3C);
        for (int i = 0; i < 19; i++) cycle("b2b", 1'b0, 1'b0, 8'hC3);
        for (int i = 0; i < 10; i++) cycle("b2b_tail", 1'b0, 1'b1, 8'h00);

        // Reset mid-word after three bits of F0.
        cycle("f0_cap", 1'b0, 1'b0, 8'hF0);
        for (int i = 0; i < 3; i++) cycle("f0_word", 1'b0, 1'b1, 8'hF0);
        cycle("mid_rst", 1'b1, 1'b1, 8'hF0);
        for (int i = 0; i < 3; i++) cycle("post_rst", 1'b0, 1'b1, 8'h00);
        cycle("81_cap", 1'b0, 1'b0, 8'h81);
        for (int i = 0; i < 11; i++) cycle("81_word", 1'b0, 1'b1, 8'h00);

        // re_n pulses during SHIFT and DONE must be ignored.
        cycle("ign_cap", 1'b0, 1'b0, 8'h6B);
        for (int i = 0; i < 3; i++) cycle("ign_shift", 1'b0, 1'b1, 8'h00);
        cycle("ign_pulse1", 1'b0, 1'b0, 8'hFF);
        for (int i = 0; i < 4; i++) cycle("ign_shift", 1'b0, 1'b1, 8'h00);
        cycle("ign_pulse2", 1'b0, 1'b0, 8'hFF);
        for (int i = 0; i < 3; i++) cycle("ign_tail", 1'b0, 1'b1, 8'h00);
        cycle("ign_pulse3", 1'b0, 1'b0, 8'hFF);
        for (int i = 0; i < 4; i++) cycle("ign_tail", 1'b0, 1'b1, 8'h00);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic r, rn;
            r  = ($urandom_range(0, 59) == 0);
            rn = ($urandom_range(0, 2) != 0);
            cycle("rand", r, rn, W'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
